// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issuer: op codes, FSM states, datapath width.
package alu_pkg;

    localparam int DATA_W = 32;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SRL = 3'b100;
    localparam logic [2:0] OP_SRA = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    // 110 and 111 have no ALU meaning.
    function automatic logic is_illegal_op(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/alu_req_fifo.sv
// Request buffer for the ALU issuer: power-of-two depth FIFO, no push/pop bypass.
module alu_req_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/alu_issuer.sv
// Buffers ALU requests, issues them one at a time to an external combinational
// ALU through registered operands, and returns tagged responses in order.
module alu_issuer
    import alu_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int TAG_W      = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic [2:0]        req_op,
    input  logic [TAG_W-1:0]  req_tag,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] alu_c,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              rsp_err,
    output logic              busy
);
    localparam int REQ_W = 2 * DATA_W + 3 + TAG_W;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, data_q, data_d;
    logic [2:0]        op_q, op_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              err_q, err_d;
    logic              ready_en_q, ready_en_d;

    logic              fifo_full, fifo_empty, fifo_pop;
    logic [REQ_W-1:0]  head;
    logic [DATA_W-1:0] head_a, head_b;
    logic [2:0]        head_op;
    logic [TAG_W-1:0]  head_tag;

    assign {head_a, head_b, head_op, head_tag} = head;

    alu_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (REQ_W)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (req_valid & req_ready),
        .push_data ({req_a, req_b, req_op, req_tag}),
        .pop       (fifo_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // ready_en_q keeps req_ready low through reset until the first clock edge.
    assign req_ready  = ready_en_q & ~fifo_full;
    assign fifo_pop   = (state_q == ST_IDLE) & ~fifo_empty;
    assign ready_en_d = 1'b1;

    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_op    = op_q;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_data  = data_q;
    assign rsp_tag   = tag_q;
    assign rsp_err   = err_q;
    assign busy      = ~fifo_empty | (state_q != ST_IDLE);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        tag_d   = tag_q;
        err_d   = err_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    a_d     = head_a;
                    b_d     = head_b;
                    err_d   = is_illegal_op(head_op);
                    op_d    = is_illegal_op(head_op) ? OP_ADD : head_op;
                    tag_d   = head_tag;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                data_d  = err_q ? '0 : alu_c;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            tag_q      <= '0;
            err_q      <= 1'b0;
            data_q     <= '0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            tag_q      <= tag_d;
            err_q      <= err_d;
            data_q     <= data_d;
            ready_en_q <= ready_en_d;
        end
    end

endmodule
